// File: rtl/fifo_serializer_if.sv
// Bundles the fifo read port and the narrow valid/ready link of
// fifo_serializer. The master modport is the serializer's view.
// The slave modport is the view of whatever drives the fifo side and
// consumes the link.
interface fifo_serializer_if #(
  parameter int Width     = 8,
  parameter int LaneWidth = 2
);
  // fifo read side
  logic                 i_fifo_empty;
  logic                 o_fifo_read;
  logic [Width-1:0]     i_fifo_rdata;

  // narrow output link
  logic                 o_valid;
  logic                 i_ready;
  logic [LaneWidth-1:0] o_data;
  logic                 o_first;
  logic                 o_last;
  logic                 o_busy;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_rdata,
    input  i_ready,
    output o_fifo_read,
    output o_valid,
    output o_data,
    output o_first,
    output o_last,
    output o_busy
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_rdata,
    output i_ready,
    input  o_fifo_read,
    input  o_valid,
    input  o_data,
    input  o_first,
    input  o_last,
    input  o_busy
  );
endinterface

// File: rtl/fifo_serializer.sv
// Drains a first-word-fall-through fifo and splits each Width-bit word
// into Width/LaneWidth beats on a narrow valid/ready link.
// The next word is popped in the same cycle the last beat of the current
// word is accepted, so words stream back-to-back without an idle cycle.
module fifo_serializer #(
  parameter int Width     = 8,
  parameter int LaneWidth = 2,
  parameter bit MsbFirst  = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fifo_serializer_if.master  bus
);

  localparam int Beats = Width / LaneWidth;
  localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  if ((LaneWidth < 1) || ((Width % LaneWidth) != 0)) begin : g_width_check
    $error("fifo_serializer: Width must be an integer multiple of LaneWidth");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Width-1:0]  shreg_q, shreg_d;

  logic              valid;
  logic              accept;
  logic              at_last;
  logic              last_acc;
  logic              load;

  // Handshake decode; every output is forced low while reset is asserted
  always_comb begin
    valid    = (state_q == SHIFT) && !i_rst;
    accept   = valid && bus.i_ready;
    at_last  = (cnt_q == LastCnt);
    last_acc = accept && at_last;
    load     = !bus.i_fifo_empty && ((state_q == IDLE) || last_acc) && !i_rst;
  end

  // Next-state logic: a load always wins, otherwise an accepted beat advances the word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = bus.i_fifo_rdata;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (accept) begin
      if (!at_last) begin
        shreg_d = MsbFirst ? (shreg_q << LaneWidth) : (shreg_q >> LaneWidth);
        cnt_d   = cnt_q + 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, beat counter and shift register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Output drive: the beat is always the slice at the outgoing end of the shift register
  always_comb begin
    bus.o_fifo_read = load;
    bus.o_valid     = valid;
    bus.o_busy      = valid;
    bus.o_first     = valid && (cnt_q == '0);
    bus.o_last      = valid && at_last;
    if (i_rst) begin
      bus.o_data = '0;
    end else if (MsbFirst) begin
      bus.o_data = shreg_q[Width-1 -: LaneWidth];
    end else begin
      bus.o_data = shreg_q[LaneWidth-1:0];
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer. Three instances cover the
// MSB-first, LSB-first and single-beat configurations. A queue models the
// fifo. Expected beats go to a scoreboard when a word is pushed and are
// compared as the selected instance presents them.
module tb_fifo_serializer;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  int         sel;

  logic       m_read, m_valid, m_first, m_last, m_busy;
  logic [7:0] m_data;
  logic       s_read, s_valid, s_first, s_last, s_busy;
  logic [7:0] s_data;

  logic [7:0] fifo_q[$];
  beat_t      sb[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_serializer_if #(.Width(8), .LaneWidth(2)) bus_msb ();
  fifo_serializer_if #(.Width(8), .LaneWidth(2)) bus_lsb ();
  fifo_serializer_if #(.Width(8), .LaneWidth(8)) bus_one ();

  fifo_serializer #(.Width(8), .LaneWidth(2), .MsbFirst(1'b1)) dut_msb (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_msb)
  );

  fifo_serializer #(.Width(8), .LaneWidth(2), .MsbFirst(1'b0)) dut_lsb (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_lsb)
  );

  fifo_serializer #(.Width(8), .LaneWidth(8), .MsbFirst(1'b1)) dut_one (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_one)
  );

  // Only the selected instance sees the fifo; the others see it empty
  assign bus_msb.i_fifo_empty = (sel == 0) ? fifo_empty : 1'b1;
  assign bus_lsb.i_fifo_empty = (sel == 1) ? fifo_empty : 1'b1;
  assign bus_one.i_fifo_empty = (sel == 2) ? fifo_empty : 1'b1;
  assign bus_msb.i_fifo_rdata = fifo_rdata;
  assign bus_lsb.i_fifo_rdata = fifo_rdata;
  assign bus_one.i_fifo_rdata = fifo_rdata;
  assign bus_msb.i_ready      = ready;
  assign bus_lsb.i_ready      = ready;
  assign bus_one.i_ready      = ready;

  // Route the selected instance's outputs to one set of monitor signals
  always_comb begin
    case (sel)
      1: begin
        m_read  = bus_lsb.o_fifo_read;
        m_valid = bus_lsb.o_valid;
        m_data  = {6'b0, bus_lsb.o_data};
        m_first = bus_lsb.o_first;
        m_last  = bus_lsb.o_last;
        m_busy  = bus_lsb.o_busy;
      end
      2: begin
        m_read  = bus_one.o_fifo_read;
        m_valid = bus_one.o_valid;
        m_data  = bus_one.o_data;
        m_first = bus_one.o_first;
        m_last  = bus_one.o_last;
        m_busy  = bus_one.o_busy;
      end
      default: begin
        m_read  = bus_msb.o_fifo_read;
        m_valid = bus_msb.o_valid;
        m_data  = {6'b0, bus_msb.o_data};
        m_first = bus_msb.o_first;
        m_last  = bus_msb.o_last;
        m_busy  = bus_msb.o_busy;
      end
    endcase
  end

  // Queue a word in the fifo model and its expected beats in the scoreboard
  task automatic push_word(input logic [7:0] w);
    int    lane;
    bit    msb;
    int    beats;
    int    shift;
    beat_t b;
    lane  = (sel == 2) ? 8 : 2;
    msb   = (sel != 1);
    beats = 8 / lane;
    fifo_q.push_back(w);
    for (int k = 0; k < beats; k++) begin
      shift   = msb ? (8 - (k + 1) * lane) : (k * lane);
      b.data  = 8'((int'(w) >> shift) & ((1 << lane) - 1));
      b.first = (k == 0);
      b.last  = (k == beats - 1);
      sb.push_back(b);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, score beats
  task automatic cycle(input logic rdy, input logic rst_v);
    @(negedge clk);
    ready      = rdy;
    rst        = rst_v;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    s_read  = m_read;
    s_valid = m_valid;
    s_data  = m_data;
    s_first = m_first;
    s_last  = m_last;
    s_busy  = m_busy;
    if (fifo_q.size() == 0) begin
      n_cmp++;
      if (s_read !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL read_when_empty: got %b expected 0", s_read);
      end
    end
    if (s_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_beat: got data %0h with no beat expected", s_data);
      end else begin
        if (s_data !== sb[0].data || s_first !== sb[0].first || s_last !== sb[0].last) begin
          n_err++;
          $display("[TB] FAIL beat: got data %0h first %b last %b expected data %0h first %b last %b",
                   s_data, s_first, s_last, sb[0].data, sb[0].first, sb[0].last);
        end
        if (rdy) void'(sb.pop_front());
      end
    end
    if (s_read === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  // Run until the fifo and scoreboard are both empty or the cycle budget runs out
  task automatic drain(input int max_cycles, input bit rand_ready, output bit done);
    int used;
    used = 0;
    while ((sb.size() != 0 || fifo_q.size() != 0) && used < max_cycles) begin
      cycle(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      used++;
    end
    done = (sb.size() == 0 && fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    bit done;
    sel = 0;
    push_word(8'hB4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      n_cmp++;
      if (s_valid !== 1'b0 || s_read !== 1'b0 || s_first !== 1'b0 || s_last !== 1'b0 ||
          s_busy !== 1'b0 || s_data !== 8'h00) begin
        n_err++;
        $display("[TB] FAIL reset_outputs: got valid %b read %b first %b last %b busy %b data %0h expected all 0",
                 s_valid, s_read, s_first, s_last, s_busy, s_data);
      end
    end
    drain(20, 1'b0, done);
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("[TB] FAIL reset_drain: got %0d beats left expected 0", sb.size());
    end
  endtask

  task automatic test_single_word();
    int read_cyc, first_v, last_v, nv, nr;
    read_cyc = -1; first_v = -1; last_v = -1; nv = 0; nr = 0;
    sel = 0;
    push_word(8'hB4);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      if (s_read) begin
        nr++;
        if (read_cyc < 0) read_cyc = i;
      end
      if (s_valid) begin
        nv++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    n_cmp++;
    if (nr != 1 || read_cyc != 0) begin
      n_err++;
      $display("[TB] FAIL single_read: got %0d reads first at %0d expected 1 at 0", nr, read_cyc);
    end
    n_cmp++;
    if (first_v != 1) begin
      n_err++;
      $display("[TB] FAIL single_latency: got first beat at %0d expected 1", first_v);
    end
    n_cmp++;
    if (nv != 4 || (last_v - first_v) != 3) begin
      n_err++;
      $display("[TB] FAIL single_beats: got %0d beats over span %0d expected 4 over 3", nv, last_v - first_v);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL single_left: got %0d beats left expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int  first_v, last_v, nv, nr, read2;
    bit  read2_last;
    first_v = -1; last_v = -1; nv = 0; nr = 0; read2 = -1; read2_last = 1'b0;
    sel = 0;
    push_word(8'hB4);
    push_word(8'h1E);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b0);
      if (s_read) begin
        nr++;
        if (nr == 2) begin
          read2      = i;
          read2_last = s_valid && s_last;
        end
      end
      if (s_valid) begin
        nv++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    n_cmp++;
    if (nr != 2 || read2 != 4) begin
      n_err++;
      $display("[TB] FAIL b2b_reads: got %0d reads second at %0d expected 2 second at 4", nr, read2);
    end
    n_cmp++;
    if (read2_last !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_read_on_last: got %b expected 1", read2_last);
    end
    n_cmp++;
    if (nv != 8 || (last_v - first_v) != 7) begin
      n_err++;
      $display("[TB] FAIL b2b_no_bubble: got %0d beats over span %0d expected 8 over 7", nv, last_v - first_v);
    end
  endtask

  task automatic test_backpressure();
    int   acc, stalls;
    logic rdy;
    acc = 0; stalls = 0;
    sel = 0;
    push_word(8'hB4);
    push_word(8'h1E);
    for (int i = 0; i < 30 && (sb.size() != 0 || fifo_q.size() != 0); i++) begin
      rdy = !(acc == 1 && stalls < 3);
      cycle(rdy, 1'b0);
      if (!rdy) begin
        stalls++;
        n_cmp++;
        if (s_valid !== 1'b1 || s_data !== 8'h03 || s_read !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL stall_hold: got valid %b data %0h read %b expected 1 3 0",
                   s_valid, s_data, s_read);
        end
      end
      if (s_valid && rdy) acc++;
    end
    n_cmp++;
    if (stalls != 3 || sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL stall_done: got %0d stalls %0d beats left expected 3 and 0", stalls, sb.size());
    end
  endtask

  task automatic test_idle();
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'(i % 2), 1'b0);
      n_cmp++;
      if (s_valid !== 1'b0 || s_read !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL idle: got valid %b read %b expected 0 0", s_valid, s_read);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int acc;
    bit done;
    acc = 0;
    sel = 0;
    push_word(8'hB4);
    for (int i = 0; i < 10 && acc < 2; i++) begin
      cycle(1'b1, 1'b0);
      if (s_valid) acc++;
    end
    n_cmp++;
    if (acc != 2) begin
      n_err++;
      $display("[TB] FAIL midrst_setup: got %0d beats accepted expected 2", acc);
    end
    sb.delete();
    push_word(8'h1E);
    cycle(1'b1, 1'b1);
    n_cmp++;
    if (s_valid !== 1'b0 || s_read !== 1'b0 || s_data !== 8'h00 || s_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_cycle: got valid %b read %b data %0h busy %b expected 0 0 0 0",
               s_valid, s_read, s_data, s_busy);
    end
    cycle(1'b1, 1'b0);
    n_cmp++;
    if (s_valid !== 1'b0 || s_read !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL midrst_after: got valid %b read %b expected 0 1", s_valid, s_read);
    end
    drain(20, 1'b0, done);
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("[TB] FAIL midrst_drain: got %0d beats left expected 0", sb.size());
    end
  endtask

  task automatic test_lsb_first();
    bit done;
    sel = 1;
    push_word(8'hB4);
    drain(20, 1'b0, done);
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("[TB] FAIL lsb_drain: got %0d beats left expected 0", sb.size());
    end
  endtask

  task automatic test_single_beat();
    int first_v, last_v, nv, nr;
    first_v = -1; last_v = -1; nv = 0; nr = 0;
    sel = 2;
    push_word(8'hB4);
    push_word(8'h5A);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      if (s_read) nr++;
      if (s_valid) begin
        nv++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    n_cmp++;
    if (nr != 2 || nv != 2 || (last_v - first_v) != 1 || sb.size() != 0) begin
      n_err++;
      $display("[TB] FAIL one_beat: got reads %0d beats %0d span %0d left %0d expected 2 2 1 0",
               nr, nv, last_v - first_v, sb.size());
    end
  endtask

  task automatic test_random_traffic();
    bit done;
    sel = 0;
    for (int i = 0; i < 6; i++) push_word(8'($urandom_range(0, 255)));
    drain(300, 1'b1, done);
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("[TB] FAIL random_drain: got %0d beats left expected 0", sb.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    ready      = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = 8'h00;
    sel        = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_idle();
    test_reset_mid_word();
    test_lsb_first();
    test_single_beat();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
